road_object_tracker: RTL and testbench

//  Owns the 3-lane road grid: scrolls coin/police objects toward the player row and steers the player lane from

---
 rtl/game_pkg.sv | 16 +
 rtl/road_object_tracker_lfsr8.sv | 22 ++
 rtl/road_object_tracker.sv | 104 ++++++++++
 tb/tb_road_object_tracker.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: object codes, lane codes and lane steering shared by the tracker and the VGA renderer
package game_pkg;
    localparam logic [1:0] OBJ_EMPTY  = 2'b00;
    localparam logic [1:0] OBJ_COIN   = 2'b01;
    localparam logic [1:0] OBJ_POLICE = 2'b10;
    localparam logic [1:0] LANE_L     = 2'd0;
    localparam logic [1:0] LANE_C     = 2'd1;
    localparam logic [1:0] LANE_R     = 2'd2;
    localparam int         NUM_LANES  = 3;

    // A lone left or right pulse moves one lane and saturates at the road edges.
    function automatic logic [1:0] steer_lane(input logic [1:0] lane, input logic left, input logic right);
        return (left && !right) ? ((lane == LANE_L) ? LANE_L : lane - 2'd1) :
               (right && !left) ? ((lane == LANE_R) ? LANE_R : lane + 2'd1) : lane;
    endfunction
endpackage

// File: rtl/road_object_tracker_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR (taps 8,6,5,4) that steps only when Adv is high
module lfsr8 (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic       Adv,
    input  logic [7:0] Seed,
    output logic [7:0] Q
);
    logic [7:0] r_q;
    logic       w_fb;

    assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];
    assign Q    = r_q;

    // Shift left with the feedback bit entering at bit 0; a nonzero seed never reaches all-zero.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset)
            r_q <= Seed;
        else if (Adv)
            r_q <= {r_q[6:0], w_fb};
    end
endmodule

// File: rtl/road_object_tracker.sv
// road_object_tracker: scrolls the 3-lane object grid, steers the player and flags coin/police hits
module road_object_tracker
    import game_pkg::*;
#(
    parameter int         ROWS      = 8,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    input  logic              DriveEn,
    input  logic              Tick,
    input  logic              LeftEn,
    input  logic              RightEn,
    input  logic              Clear,
    output logic [1:0]        PlayerLane,
    output logic [ROWS*6-1:0] Grid,
    output logic              HitEn,
    output logic              CoinEn,
    output logic              PoliceEn
);
    logic [1:0] r_grid   [ROWS][NUM_LANES];
    logic [1:0] w_grid_n [ROWS][NUM_LANES];
    logic [1:0] r_lane;
    logic       r_coin;
    logic       r_police;
    logic       r_hit;
    logic [7:0] w_lfsr;
    logic       w_tick;
    logic       w_adv;
    logic [1:0] w_obj;
    logic       w_row0_busy;
    logic       w_hit_coin;
    logic       w_hit_police;
    logic       w_coin_n;
    logic       w_police_n;

    assign w_tick       = DriveEn & Tick;
    assign w_adv        = w_tick & ~Clear;
    assign w_obj        = r_grid[ROWS-1][r_lane];
    assign w_row0_busy  = (r_grid[0][0] != OBJ_EMPTY) | (r_grid[0][1] != OBJ_EMPTY) | (r_grid[0][2] != OBJ_EMPTY);
    assign w_hit_coin   = DriveEn & (w_obj == OBJ_COIN);
    assign w_hit_police = DriveEn & (w_obj == OBJ_POLICE);
    // A tick closes the hold window; police outranks a coin within the same window.
    assign w_police_n   = w_hit_police | (r_police & ~w_tick);
    assign w_coin_n     = (w_hit_coin | (r_coin & ~w_tick)) & ~w_police_n;

    assign PlayerLane = r_lane;
    assign HitEn      = r_hit;
    assign CoinEn     = r_coin;
    assign PoliceEn   = r_police;

    lfsr8 u_lfsr (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .Adv      (w_adv),
        .Seed     (LFSR_SEED),
        .Q        (w_lfsr)
    );

    // Next grid: a tick scrolls and spawns (row 0 left empty after an occupied row); otherwise a hit clears its cell.
    always_comb begin
        w_grid_n = r_grid;
        if (w_tick) begin
            for (int r = 1; r < ROWS; r++)
                w_grid_n[r] = r_grid[r-1];
            w_grid_n[0] = '{default: OBJ_EMPTY};
            if (!w_row0_busy && w_lfsr[1:0] != 2'd3)
                w_grid_n[0][w_lfsr[1:0]] = w_lfsr[2] ? OBJ_POLICE : OBJ_COIN;
        end else if (w_obj != OBJ_EMPTY) begin
            w_grid_n[ROWS-1][r_lane] = OBJ_EMPTY;
        end
    end

    // State registers: everything frozen outside the driving phase.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            r_grid   <= '{default: OBJ_EMPTY};
            r_lane   <= LANE_C;
            r_coin   <= 1'b0;
            r_police <= 1'b0;
            r_hit    <= 1'b0;
        end else if (Clear) begin
            r_grid   <= '{default: OBJ_EMPTY};
            r_lane   <= LANE_C;
            r_coin   <= 1'b0;
            r_police <= 1'b0;
            r_hit    <= 1'b0;
        end else if (DriveEn) begin
            r_grid   <= w_grid_n;
            r_lane   <= steer_lane(r_lane, LeftEn, RightEn);
            r_coin   <= w_coin_n;
            r_police <= w_police_n;
            r_hit    <= w_coin_n | w_police_n;
        end
    end

    // Flatten the grid: row r lane l occupies bits [(r*3+l)*2 +: 2].
    always_comb begin
        Grid = '0;
        for (int r = 0; r < ROWS; r++)
            for (int l = 0; l < NUM_LANES; l++)
                Grid[(r*NUM_LANES+l)*2 +: 2] = r_grid[r][l];
    end
endmodule

// File: tb/tb_road_object_tracker.sv
// tb_road_object_tracker: directed checks plus a long random-steering run against a vector-based reference model
module tb_road_object_tracker;
    localparam int ROWS = 8;
    localparam int PR   = (ROWS - 1) * 3;

    logic              clk      = 1'b0;
    logic              Reset    = 1'b0;
    logic              DriveEn  = 1'b0;
    logic              Tick     = 1'b0;
    logic              LeftEn   = 1'b0;
    logic              RightEn  = 1'b0;
    logic              Clear    = 1'b0;
    logic [1:0]        PlayerLane;
    logic [ROWS*6-1:0] Grid;
    logic              HitEn;
    logic              CoinEn;
    logic              PoliceEn;

    int n_checks = 0;
    int n_err    = 0;

    logic [ROWS*6-1:0] m_grid = '0;
    logic [1:0]        m_lane = 2'd1;
    logic              m_c    = 1'b0;
    logic              m_p    = 1'b0;
    logic [7:0]        m_lfsr = 8'hA5;
    int                m_overlaps = 0;
    logic [ROWS*6-1:0] ng;
    logic              nc, np;
    logic [1:0]        mo;

    road_object_tracker #(.ROWS(ROWS), .LFSR_SEED(8'hA5)) dut (
        .CLOCK_50   (clk),
        .Reset      (Reset),
        .DriveEn    (DriveEn),
        .Tick       (Tick),
        .LeftEn     (LeftEn),
        .RightEn    (RightEn),
        .Clear      (Clear),
        .PlayerLane (PlayerLane),
        .Grid       (Grid),
        .HitEn      (HitEn),
        .CoinEn     (CoinEn),
        .PoliceEn   (PoliceEn)
    );

    always #5 clk = ~clk;

    // Reference model working on the flat grid vector: scroll is a 6-bit shift, LFSR feedback is a masked parity.
    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            m_grid = '0; m_lane = 2'd1; m_c = 1'b0; m_p = 1'b0; m_lfsr = 8'hA5;
        end else if (Clear) begin
            m_grid = '0; m_lane = 2'd1; m_c = 1'b0; m_p = 1'b0;
        end else if (DriveEn) begin
            mo = m_grid[(PR + m_lane)*2 +: 2];
            ng = m_grid; nc = m_c; np = m_p;
            if (mo != 2'b00) begin
                m_overlaps++;
                ng[(PR + m_lane)*2 +: 2] = 2'b00;
            end
            if (Tick) begin
                ng = m_grid << 6;
                if (m_grid[5:0] == 6'd0 && m_lfsr[1:0] != 2'd3)
                    ng[m_lfsr[1:0]*2 +: 2] = m_lfsr[2] ? 2'b10 : 2'b01;
                m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
                nc = 1'b0; np = 1'b0;
            end
            if (mo == 2'b10) begin np = 1'b1; nc = 1'b0; end
            else if (mo == 2'b01 && !np) nc = 1'b1;
            if (LeftEn && !RightEn && m_lane != 2'd0) m_lane = m_lane - 2'd1;
            else if (RightEn && !LeftEn && m_lane < 2'd2) m_lane = m_lane + 2'd1;
            m_grid = ng; m_c = nc; m_p = np;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        Tick = 1'b1;
        step();
        Tick = 1'b0;
    endtask

    task automatic pulse(input logic l, input logic r);
        LeftEn = l; RightEn = r;
        step();
        LeftEn = 1'b0; RightEn = 1'b0;
    endtask

    task automatic steer_to(input logic [1:0] t);
        for (int i = 0; i < 4 && PlayerLane != t; i++)
            pulse(PlayerLane > t, PlayerLane < t);
        check("steer_to", PlayerLane, t);
    endtask

    task automatic check_flags(input string tag, input logic c, input logic p);
        check({tag, "_coin"}, CoinEn, c);
        check({tag, "_police"}, PoliceEn, p);
        check({tag, "_hit"}, HitEn, c | p);
    endtask

    // One random-run cycle, compared against the model and the structural invariants.
    task automatic rnd_cycle(input logic tk, inout int ev, inout logic prev);
        int   occ;
        logic adj;
        Tick = tk; LeftEn = ($urandom_range(0, 3) == 0); RightEn = ($urandom_range(0, 3) == 0);
        step();
        Tick = 1'b0; LeftEn = 1'b0; RightEn = 1'b0;
        if (HitEn && (!prev || tk)) ev++;
        prev = HitEn;
        check("rnd_grid", Grid, m_grid);
        check("rnd_lane", PlayerLane, m_lane);
        check("rnd_coin", CoinEn, m_c);
        check("rnd_police", PoliceEn, m_p);
        check("rnd_hit", HitEn, m_c | m_p);
        check("rnd_both", CoinEn & PoliceEn, 1'b0);
        check("rnd_lfsr_nz", dut.u_lfsr.Q == 8'h00, 1'b0);
        occ = int'(Grid[1:0] != 2'b00) + int'(Grid[3:2] != 2'b00) + int'(Grid[5:4] != 2'b00);
        check("rnd_row0_le1", occ <= 1, 1'b1);
        adj = 1'b0;
        for (int r = 0; r < ROWS - 1; r++)
            if (Grid[r*6 +: 6] != 6'd0 && Grid[(r+1)*6 +: 6] != 6'd0) adj = 1'b1;
        check("rnd_no_adjacent", adj, 1'b0);
    endtask

    initial begin
        logic       found;
        logic [1:0] cl;
        int         ev, ov0;
        logic       prev;

        #1 Reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 Reset = 1'b0;
        check("rst_grid", Grid, 48'h0);
        check("rst_lane", PlayerLane, 2'd1);
        check_flags("rst", 1'b0, 1'b0);
        check("rst_lfsr", dut.u_lfsr.Q, 8'hA5);

        DriveEn = 1'b1;
        tick();
        check("spawn1_police_l1", Grid, 48'h8);
        tick();
        check("spawn2_gap", Grid, 48'h200);
        tick();
        check("spawn3", Grid, 48'h8008);

        DriveEn = 1'b0;
        Tick = 1'b1; LeftEn = 1'b1;
        repeat (2) step();
        Tick = 1'b0; LeftEn = 1'b0;
        check("frz_grid", Grid, 48'h8008);
        check("frz_lane", PlayerLane, 2'd1);
        check_flags("frz", 1'b0, 1'b0);
        check("frz_lfsr", dut.u_lfsr.Q, 8'h2A);
        DriveEn = 1'b1;
        tick();
        check("post_frz_gap", Grid, 48'h200200);
        tick();
        check("post_frz_spawn_l0", Grid, 48'h8008002);

        pulse(1'b1, 1'b0);
        check("left_to_0", PlayerLane, 2'd0);
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1, 1'b0);
            check("left_sat0", PlayerLane, 2'd0);
        end
        pulse(1'b0, 1'b1);
        check("right_to_1", PlayerLane, 2'd1);
        pulse(1'b0, 1'b1);
        check("right_to_2", PlayerLane, 2'd2);
        pulse(1'b0, 1'b1);
        check("right_sat2", PlayerLane, 2'd2);
        pulse(1'b1, 1'b1);
        check("both_nochange", PlayerLane, 2'd2);

        Clear = 1'b1; Tick = 1'b1;
        step();
        Clear = 1'b0; Tick = 1'b0;
        check("clr_grid", Grid, 48'h0);
        check("clr_lane", PlayerLane, 2'd1);
        check_flags("clr", 1'b0, 1'b0);
        check("clr_lfsr_kept", dut.u_lfsr.Q, 8'hA9);

        found = 1'b0; cl = 2'd0;
        for (int i = 0; i < 400 && !found; i++) begin
            for (int l = 0; l < 3; l++)
                if (!found && m_grid[((ROWS-2)*3 + l)*2 +: 2] == 2'b01) begin found = 1'b1; cl = 2'(l); end
            if (!found) tick();
        end
        check("coin_found", found, 1'b1);
        if (found) begin
            steer_to(cl);
            tick();
            check_flags("coin_e1", 1'b0, 1'b0);
            check("coin_in_row7", Grid[(PR + cl)*2 +: 2], 2'b01);
            step();
            check_flags("coin_e2", 1'b1, 1'b0);
            check("coin_cell_clr", Grid[(PR + cl)*2 +: 2], 2'b00);
            repeat (3) step();
            check_flags("coin_hold", 1'b1, 1'b0);
            tick();
            check_flags("coin_drop", 1'b0, 1'b0);
            step();
            check_flags("coin_no_repeat", 1'b0, 1'b0);
        end

        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (m_grid[((ROWS-2)*3 + 2)*2 +: 2] == 2'b10) found = 1'b1;
            else tick();
        end
        check("police_found", found, 1'b1);
        if (found) begin
            steer_to(2'd1);
            tick();
            check("pol_in_row7_l2", Grid[(PR + 2)*2 +: 2], 2'b10);
            check_flags("pol_pre", 1'b0, 1'b0);
            pulse(1'b0, 1'b1);
            check("pol_lane2", PlayerLane, 2'd2);
            check_flags("pol_old_lane", 1'b0, 1'b0);
            step();
            check_flags("pol_hit", 1'b0, 1'b1);
        end

        ev = 0; ov0 = m_overlaps; prev = HitEn;
        for (int t = 0; t < 1000; t++) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) rnd_cycle(1'b0, ev, prev);
            rnd_cycle(1'b1, ev, prev);
        end
        check("flag_count", ev, m_overlaps - ov0);

        #2 Reset = 1'b1;
        #1;
        check("async_rst_grid", Grid, 48'h0);
        check("async_rst_lane", PlayerLane, 2'd1);
        check_flags("async_rst", 1'b0, 1'b0);
        step();
        Reset = 1'b0;
        step();
        check_flags("post_rst_quiet", 1'b0, 1'b0);
        tick();
        check("post_rst_spawn", Grid, 48'h8);
        step();
        check_flags("post_rst_noflag", 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
